// File: rtl/axi4_stream_downsizer_pkg.sv
// Shared types and slice-mask helpers for the AXI4-Stream downsizer.
// Helpers work on fixed maximum-width vectors; callers zero-extend their operands and truncate the results.
package axi4_stream_downsizer_pkg;

  localparam int MAX_RATIO       = 16;
  localparam int MAX_SLICE_BYTES = 32;
  localparam int MAX_KEEP        = MAX_RATIO * MAX_SLICE_BYTES;

  typedef logic [MAX_RATIO-1:0] slice_mask_t;
  typedef logic [MAX_KEEP-1:0]  keep_vec_t;

  // Bit s of the result is set when any tkeep bit of slice s is set.
  function automatic slice_mask_t slice_keep_mask(input keep_vec_t keep,
                                                  input int unsigned ratio,
                                                  input int unsigned slice_bytes);
    keep_vec_t   ones;
    slice_mask_t m;
    ones = ~({MAX_KEEP{1'b1}} << slice_bytes);
    m    = '0;
    for (int unsigned s = 0; s < MAX_RATIO; s++) begin
      if (s < ratio && ((keep >> (s * slice_bytes)) & ones) != '0)
        m = m | (slice_mask_t'(1) << s);
    end
    return m;
  endfunction

  // Index of the highest set bit; 0 for an empty mask.
  function automatic int unsigned msb_index(input slice_mask_t mask);
    int unsigned r;
    r = 0;
    for (int unsigned s = 0; s < MAX_RATIO; s++) begin
      if (((mask >> s) & slice_mask_t'(1)) != '0) r = s;
    end
    return r;
  endfunction

  // Lowest set index at or above idx; returns idx when there is none.
  function automatic int unsigned next_set_index(input slice_mask_t mask, input int unsigned idx);
    int unsigned r;
    r = idx;
    for (int s = MAX_RATIO - 1; s >= 0; s--) begin
      if (s >= int'(idx) && ((mask >> s) & slice_mask_t'(1)) != '0) r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave modports.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1
);
  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [KEEP_WIDTH-1:0] tstrb;
  logic                  tlast;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, output tready);
endinterface

// File: rtl/axi4_stream_downsizer_slice_ptr.sv
// Slice pointer finder for null-slice skipping (instantiated only with AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN).
// Gives the first and last non-null slice of an incoming word and the next non-null slice of the buffered word.
module axi4_stream_downsizer_slice_ptr
  import axi4_stream_downsizer_pkg::*;
#(
  parameter int RATIO     = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [RATIO-1:0]     cap_mask_i,
  input  logic [RATIO-1:0]     buf_mask_i,
  input  logic [IDX_WIDTH-1:0] idx_i,
  output logic [IDX_WIDTH-1:0] cap_first_o,
  output logic [IDX_WIDTH-1:0] cap_last_o,
  output logic                 cap_any_o,
  output logic [IDX_WIDTH-1:0] next_idx_o
);

  assign cap_first_o = IDX_WIDTH'(next_set_index(slice_mask_t'(cap_mask_i), 0));
  assign cap_last_o  = IDX_WIDTH'(msb_index(slice_mask_t'(cap_mask_i)));
  assign cap_any_o   = |cap_mask_i;
  assign next_idx_o  = IDX_WIDTH'(next_set_index(slice_mask_t'(buf_mask_i), 32'(idx_i) + 32'd1));

endmodule

// File: rtl/axi4_stream_downsizer.sv
// Wide-to-narrow AXI4-Stream width converter, least-significant slice first; drops trailing empty slices of tlast words.
// Optional: define AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN to skip all-null slices in every word.
module axi4_stream_downsizer
  import axi4_stream_downsizer_pkg::*;
#(
  parameter int RX_TDATA_WIDTH = 64,
  parameter int TX_TDATA_WIDTH = 16,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  pkt_i,
  axi4_stream_if.master pkt_o
);

  localparam int RATIO         = RX_TDATA_WIDTH / TX_TDATA_WIDTH;
  localparam int IDX_WIDTH     = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam int RX_KEEP_WIDTH = RX_TDATA_WIDTH / 8;
  localparam int TX_KEEP_WIDTH = TX_TDATA_WIDTH / 8;

  if (RATIO < 2 || RATIO > MAX_RATIO || (RX_TDATA_WIDTH % TX_TDATA_WIDTH) != 0 ||
      (TX_TDATA_WIDTH % 8) != 0 || TX_KEEP_WIDTH > MAX_SLICE_BYTES) begin : g_bad_params
    $error("axi4_stream_downsizer: unsupported width combination");
  end

  logic [RX_TDATA_WIDTH-1:0] data_q;
  logic [RX_KEEP_WIDTH-1:0]  keep_q, strb_q;
  logic                      tlast_q;
  logic [TID_WIDTH-1:0]      tid_q;
  logic [TDEST_WIDTH-1:0]    tdest_q;
  logic [TUSER_WIDTH-1:0]    tuser_q;
  logic                      full_q, full_d;
  logic [IDX_WIDTH-1:0]      idx_q, idx_d;
  logic [IDX_WIDTH-1:0]      last_idx_q, last_idx_d;

  logic                 rx_hs, tx_hs, final_beat;
  logic                 cap_valid;
  logic [IDX_WIDTH-1:0] cap_first, cap_last, adv_idx;
  logic [RATIO-1:0]     in_mask;

  assign final_beat   = (idx_q == last_idx_q);
  assign tx_hs        = full_q && pkt_o.tready;
  assign pkt_i.tready = !rst_i && (!full_q || (tx_hs && final_beat));
  assign rx_hs        = pkt_i.tvalid && pkt_i.tready;

  assign in_mask = RATIO'(slice_keep_mask(keep_vec_t'(pkt_i.tkeep), RATIO, TX_KEEP_WIDTH));

`ifdef AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
  logic [RATIO-1:0] buf_mask;
  logic             cap_any;

  assign buf_mask = RATIO'(slice_keep_mask(keep_vec_t'(keep_q), RATIO, TX_KEEP_WIDTH));

  axi4_stream_downsizer_slice_ptr #(
    .RATIO     (RATIO),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_slice_ptr (
    .cap_mask_i  (in_mask),
    .buf_mask_i  (buf_mask),
    .idx_i       (idx_q),
    .cap_first_o (cap_first),
    .cap_last_o  (cap_last),
    .cap_any_o   (cap_any),
    .next_idx_o  (adv_idx)
  );

  // An all-null tlast word still yields one empty beat so the packet boundary survives.
  assign cap_valid = cap_any || pkt_i.tlast;
`else
  assign cap_valid = 1'b1;
  assign cap_first = '0;
  assign cap_last  = pkt_i.tlast ? IDX_WIDTH'(msb_index(slice_mask_t'(in_mask)))
                                 : IDX_WIDTH'(RATIO - 1);
  assign adv_idx   = idx_q + IDX_WIDTH'(1);
`endif

  always_comb begin
    full_d     = full_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    if (rx_hs) begin
      full_d     = cap_valid;
      idx_d      = cap_first;
      last_idx_d = cap_last;
    end else if (tx_hs) begin
      if (final_beat) full_d = 1'b0;
      else            idx_d  = adv_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q     <= 1'b0;
      idx_q      <= '0;
      last_idx_q <= '0;
      data_q     <= '0;
      keep_q     <= '0;
      strb_q     <= '0;
      tlast_q    <= 1'b0;
      tid_q      <= '0;
      tdest_q    <= '0;
      tuser_q    <= '0;
    end else begin
      full_q     <= full_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      if (rx_hs) begin
        data_q  <= pkt_i.tdata;
        keep_q  <= pkt_i.tkeep;
        strb_q  <= pkt_i.tstrb;
        tlast_q <= pkt_i.tlast;
        tid_q   <= pkt_i.tid;
        tdest_q <= pkt_i.tdest;
        tuser_q <= pkt_i.tuser;
      end
    end
  end

  assign pkt_o.tvalid = full_q;
  assign pkt_o.tdata  = TX_TDATA_WIDTH'(data_q >> (TX_TDATA_WIDTH * int'(idx_q)));
  assign pkt_o.tkeep  = TX_KEEP_WIDTH'(keep_q >> (TX_KEEP_WIDTH * int'(idx_q)));
  assign pkt_o.tstrb  = TX_KEEP_WIDTH'(strb_q >> (TX_KEEP_WIDTH * int'(idx_q)));
  assign pkt_o.tlast  = tlast_q && final_beat;
  assign pkt_o.tid    = tid_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tuser  = tuser_q;

endmodule

// File: tb/tb_axi4_stream_downsizer.sv
// Self-checking bench for axi4_stream_downsizer (64 -> 16) against a slice-list reference model.
module tb_axi4_stream_downsizer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(64)) rx_if ();
  axi4_stream_if #(.DATA_WIDTH(16)) tx_if ();

  axi4_stream_downsizer #(
    .RX_TDATA_WIDTH (64),
    .TX_TDATA_WIDTH (16),
    .TID_WIDTH      (1),
    .TDEST_WIDTH    (1),
    .TUSER_WIDTH    (1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .pkt_i (rx_if),
    .pkt_o (tx_if)
  );

  int passed = 0;
  int total  = 0;
  int beat_count = 0;
  int cyc = 0;
  int tready_mode = 0;
  logic [23:0] exp_q[$];
  int beat_cyc_q[$];
  logic stall_prev = 1'b0;
  logic [23:0] prev_cur = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: decide which 16-bit slices a word produces, then list them in order.
  function automatic void model_push(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                                     input logic l, input logic id, input logic de, input logic us);
    int sel[$];
    logic [3:0] m;
    int top;
    for (int i = 0; i < 4; i++) m[i] = ((k >> (2 * i)) & 8'h3) != 8'h0;
`ifdef AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
    for (int i = 0; i < 4; i++) if (m[i]) sel.push_back(i);
    if (sel.size() == 0 && l) sel.push_back(0);
`else
    top = 3;
    if (l) begin
      top = 0;
      for (int i = 0; i < 4; i++) if (m[i]) top = i;
    end
    for (int i = 0; i <= top; i++) sel.push_back(i);
`endif
    for (int n = 0; n < sel.size(); n++) begin
      exp_q.push_back({16'(d >> (16 * sel[n])), 2'(k >> (2 * sel[n])), 2'(s >> (2 * sel[n])),
                       l && (n == sel.size() - 1), id, de, us});
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (tready_mode == 0) tx_if.tready = 1'b1;
    else                  tx_if.tready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    logic [23:0] cur;
    cur = {tx_if.tdata, tx_if.tkeep, tx_if.tstrb, tx_if.tlast, tx_if.tid, tx_if.tdest, tx_if.tuser};
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) chk("hold", {tx_if.tvalid, cur}, {1'b1, prev_cur});
      if (tx_if.tvalid && tx_if.tready) begin
        if (exp_q.size() == 0) chk("beat_expected", 64'(exp_q.size()), 64'd1);
        else                   chk("beat", cur, exp_q.pop_front());
        beat_count++;
        beat_cyc_q.push_back(cyc);
      end
      stall_prev = tx_if.tvalid && !tx_if.tready;
      prev_cur   = cur;
      if (rx_if.tvalid && rx_if.tready)
        model_push(rx_if.tdata, rx_if.tkeep, rx_if.tstrb, rx_if.tlast, rx_if.tid, rx_if.tdest, rx_if.tuser);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_word(input logic [63:0] d, input logic [7:0] k, input logic [7:0] s,
                           input logic l, input logic id, input logic de, input logic us);
    logic hs;
    int n;
    rx_if.tvalid = 1'b1; rx_if.tdata = d; rx_if.tkeep = k; rx_if.tstrb = s;
    rx_if.tlast = l; rx_if.tid = id; rx_if.tdest = de; rx_if.tuser = us;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 1000) begin
      @(negedge clk);
      hs = rx_if.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) chk("rx_handshake_timeout", hs, 1'b1);
    rx_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    logic [7:0] k;
    logic [63:0] d;
    int nw, r;
    rx_if.tvalid = 1'b0; rx_if.tdata = '0; rx_if.tkeep = '0; rx_if.tstrb = '0;
    rx_if.tlast = 1'b0; rx_if.tid = '0; rx_if.tdest = '0; rx_if.tuser = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tx_if.tvalid, 1'b0);
    chk("rst_tlast", tx_if.tlast, 1'b0);
    chk("rst_tdata", tx_if.tdata, 16'h0);
    chk("rst_rx_tready", rx_if.tready, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("idle_rx_tready", rx_if.tready, 1'b1);
    chk("idle_tvalid", tx_if.tvalid, 1'b0);
    @(posedge clk); #1;

    // single full word, tready = 1
    send_word(64'h4444_3333_2222_1111, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("w1_tdata", tx_if.tdata, 16'h1111 * (i + 1));
      chk("w1_tlast", tx_if.tlast, i == 3);
      chk("w1_rx_tready", rx_if.tready, i == 3);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1_done_tvalid", tx_if.tvalid, 1'b0);
    @(posedge clk); #1;

    // two-word packet with a partial final word
    b0 = beat_count;
    send_word(64'hA4A4_A3A3_A2A2_A1A1, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(64'hB4B4_B3B3_B2B2_B1B1, 8'h0F, 8'h0F, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain();
    chk("pkt2_beats", beat_count - b0, 6);

    // back-to-back words, no bubble
    b0 = beat_count;
    for (int w = 0; w < 6; w++)
      send_word({$urandom, $urandom}, 8'hFF, 8'hFF, w == 5, 1'b1, 1'b1, 1'b0);
    wait_drain();
    chk("b2b_beats", beat_count - b0, 24);
    chk("b2b_span", beat_cyc_q[b0 + 23] - beat_cyc_q[b0], 23);

    // reset in the middle of a word
    send_word(64'hDDDD_CCCC_BBBB_AAAA, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    b0 = beat_count;
    @(negedge clk);
    chk("midrst_tvalid", tx_if.tvalid, 1'b0);
    repeat (4) @(negedge clk);
    chk("midrst_no_beats", beat_count - b0, 0);
    @(posedge clk); #1;
    send_word(64'h8888_7777_6666_5555, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_slice0", tx_if.tdata, 16'h5555);
    wait_drain();

    // all-zero tkeep on a tlast word
    send_word(64'h1234_5678_9ABC_DEF0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("nullw_beat", {tx_if.tvalid, tx_if.tkeep, tx_if.tlast}, {1'b1, 2'b00, 1'b1});
    @(negedge clk);
    chk("nullw_single", tx_if.tvalid, 1'b0);
    @(posedge clk); #1;

`ifdef AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN
    b0 = beat_count;
    send_word(64'h4444_3333_2222_1111, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("skip_first_slice", tx_if.tdata, 16'h3333);
    wait_drain();
    chk("skip_beats", beat_count - b0, 2);
`endif

    // random packets, random gaps and backpressure
    tready_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        r = $urandom_range(0, 9);
        if (w != nw - 1) k = (r < 7) ? 8'hFF : 8'($urandom);
        else             k = (r < 4) ? 8'hFF : (r < 9) ? 8'($urandom) : 8'h00;
        d = {$urandom, $urandom};
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send_word(d, k, 8'($urandom), w == nw - 1, 1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    tready_mode = 0;
    wait_drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4_stream_downsizer.md
Name: axi4_stream_downsizer

Overview:
- Width converter from a wide AXI4-Stream word to a sequence of narrow output beats, least-significant slice first.
- Sits between a wide datapath (e.g. DMA/packet buffer) and a narrow sink. It is the mirror of the stream upsizer and is paired with it in loopback.
- Preserves tlast, tkeep and tstrb, and drops trailing empty slices of the final word.

Parameters:
- RX_TDATA_WIDTH, 64, input tdata width in bits; integer multiple of TX_TDATA_WIDTH.
- TX_TDATA_WIDTH, 16, output tdata width in bits; multiple of 8.
- TID_WIDTH, 1, tid width.
- TDEST_WIDTH, 1, tdest width.
- TUSER_WIDTH, 1, tuser width.
- Derived: RATIO = RX_TDATA_WIDTH / TX_TDATA_WIDTH.
- Derived: IDX_WIDTH = max(1, $clog2(RATIO)).
- Elaboration error if RATIO < 2 or the widths are not byte/ratio aligned.

Ports:
- clk_i  input  1  clock, the only clock.
- rst_i  input  1  synchronous reset, active-high.
- pkt_i  axi4_stream_if.slave  RX_TDATA_WIDTH  wide input stream (tdata, tkeep, tstrb, tlast, tid, tdest, tuser, tvalid, tready).
- pkt_o  axi4_stream_if.master  TX_TDATA_WIDTH  narrow output stream, same signal set.

Behaviour:
- Reset is synchronous on posedge clk_i while rst_i = 1. Reset clears:
  - full_q = 0, idx_q = 0, last_idx_q = 0;
  - data, keep, strb, side-band and tlast buffers = 0.
- Reset outputs:
  - pkt_o.tvalid = 0, pkt_o.tlast = 0, all pkt_o payload = 0;
  - pkt_i.tready = 0 while rst_i = 1.
- A reset mid-word discards the buffered word, and no further beats of it are emitted.
- Storage is one wide word buffer plus full_q, the current slice index idx_q and the final index last_idx_q. There is no other state.
- pkt_i.tready = !rst_i && (!full_q || (tx_handshake && idx_q == last_idx_q)). This gives back-to-back words with no bubble.
- Capture on rx_handshake loads the buffer, sets full_q = 1, and sets idx_q to the first emitted slice (0 in base mode).
- last_idx_q:
  - for a non-tlast word: RATIO-1;
  - for a tlast word: the index of the highest slice with any tkeep bit set;
  - if tkeep is all zero on a tlast word: 0.
- Latency: the first output beat is valid in the cycle after the input handshake. A word yields (last_idx_q+1) beats at one beat per cycle when pkt_o.tready = 1.
- Output mapping:
  - pkt_o.tvalid = full_q;
  - tdata, tkeep, tstrb = slice idx_q of the buffer;
  - pkt_o.tlast = buf_tlast && idx_q == last_idx_q;
  - tid, tdest, tuser = the values captured with the word, repeated on every beat of that word.
- Beats of one word:
  - on tx_handshake with idx_q < last_idx_q, idx_q advances;
  - on tx_handshake at idx_q == last_idx_q, either a new word is captured that cycle or full_q clears.
- While pkt_o.tready = 0, all pkt_o outputs are held stable (AXI rule). pkt_i.tready stays 0 while full_q = 1.
- Simultaneous final-beat tx_handshake and rx_handshake: the new word is loaded, full_q stays 1, and idx_q is reset to its first slice.
- The all-zero-tkeep tlast word emits exactly one beat with tkeep = 0 and tlast = 1, so packet boundaries are never lost.

Optional Feature:
- AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN defined:
  - slices whose tkeep is all zero are never emitted, in any word;
  - at capture, idx_q is the lowest non-null slice, and each advance jumps to the next non-null slice;
  - a non-tlast word with tkeep all zero is consumed with no output beat, and full_q is not set;
  - exception: an all-null tlast word still emits one tkeep = 0, tlast = 1 beat.
- Undefined: null slices in non-tlast words are emitted as-is with tkeep = 0.

Decomposition:
- Package axi4_stream_downsizer_pkg holds:
  - function slice_keep_mask(keep, ratio), returning a per-slice any-keep vector;
  - function msb_index(mask);
  - function next_set_index(mask, idx).
- Sub-module axi4_stream_downsizer_slice_ptr: combinational next-index and last-index finder from the slice mask. Used only under AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN; base mode uses idx_q+1.

Test Plan:
- 64-to-16 with tready = 1: one word 0x4444_3333_2222_1111, tkeep = 0xFF, tlast = 1 -> beats 0x1111, 0x2222, 0x3333, 0x4444; tlast only on the 4th; pkt_i.tready low for 3 cycles.
- Last word with tkeep = 0x0F -> 2 beats, tlast on beat 2 (tkeep 0x3); total packet of 2 words = 6 beats.
- Random pkt_o.tready (50%) and random input gaps over 1000 packets -> output matches the byte-stream scoreboard; payload stable while tvalid && !tready; tid/tdest constant per word.
- Back-to-back words with tready = 1 -> continuous tvalid, 4N beats for N words, no bubble at word boundaries.
- rst_i asserted at beat 2 of a word -> the next cycle has tvalid = 0 and no further beats of that word; the next word after reset is emitted from slice 0.
- tlast word with tkeep = 0x00 -> one beat, tkeep = 0, tlast = 1.
- With AXI4_STREAM_DOWNSIZER_SKIP_NULL_EN, a non-last word with tkeep = 0xF0 -> 2 beats from slices 2 and 3.
